trb_stream_reader: RTL
======================

# trb_stream_reader

Readout engine for the trace-buffer BRAM. It drives the BRAM read port (`rd_addr`/`rd_data`, one-cycle registered read) from a programmed base address and word count. It returns the words in order as a valid/ready stream towards the debug transport, with full throughput and lossless backpressure. It sits beside the trace writer, sharing the BRAM, and only ever touches the read port.

## Interface
- `ADDR_WIDTH`, default `TRB_ADDR_WIDTH`: BRAM address width; depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, default `TRB_WIDTH`: BRAM word width.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `start_i` in 1: begin a readout. Sampled only in IDLE; ignored otherwise.
- `base_addr_i` in ADDR_WIDTH: first word address, captured on start.
- `count_i` in ADDR_WIDTH+1: words to read, captured on start. Values above 2^ADDR_WIDTH are clamped to 2^ADDR_WIDTH.
- `abort_i` in 1: cancel the readout in progress.
- `rd_addr_o` out ADDR_WIDTH: BRAM read address (registered).
- `rd_data_i` in DATA_WIDTH: BRAM read data, valid one cycle after the address.
- `data_o` out DATA_WIDTH: stream data.
- `valid_o` out 1: stream valid.
- `ready_i` in 1: stream ready.
- `last_o` out 1: marks the final word (see Configuration).
- `busy_o` out 1: high whenever the state is not IDLE.
- `done_o` out 1: one-cycle pulse on readout completion.

## Operation
- States are `IDLE`, `RUN` and `DRAIN`.
- IDLE to RUN: `start_i`=1 and clamped count ≠ 0. The block loads `addr_q` = base, `remaining` = count and `issued` = 0.
- IDLE with `start_i`=1 and count = 0: the block stays in IDLE, pulses `done_o` the next cycle and emits no data.
- RUN: one read is issued per cycle while `occ + inflight - pop < 2`.
  - `occ` is the output-buffer occupancy (0..2).
  - `inflight` is 1 when a read was issued the previous cycle.
  - `pop` = `valid_o & ready_i`.
  - On each issue, `addr_q` increments modulo 2^ADDR_WIDTH (wraps from all-ones to 0) and `issued` increments.
- RUN to DRAIN: when `issued` reaches the count.
- DRAIN to IDLE: on the pop of the final word. `done_o` is registered high for exactly one cycle after that edge.
- `rd_data_i` is written into the 2-entry output buffer on the cycle after its issue. The buffer never overflows under the issue rule above.
- Handshake rules:
  - Once `valid_o` is high, `valid_o` and `data_o` stay stable until `ready_i`.
  - `valid_o` never depends combinationally on `ready_i`.
- Abort (`abort_i`=1 in RUN or DRAIN): next edge goes to IDLE, flushes the buffer and in-flight word, drives `valid_o` low and does not pulse `done_o`. Abort takes priority over a simultaneous pop.
- `start_i` coinciding with `abort_i` in IDLE: start wins.
- `rd_addr_o` holds its value when no read is issued. There is no read enable; a read is tracked by the `inflight` flag only.

## Timing
- Reset values: state IDLE, `rd_addr_o`=0, `data_o`=0, `valid_o`=0, `last_o`=0, `busy_o`=0, `done_o`=0. Buffer and counters are cleared.
- Reset mid-readout discards everything immediately and asynchronously.
- Start sampled at edge E0: `rd_addr_o`=base after E0, data captured at E2, `valid_o` high after E2. Latency is 2 cycles.
- With `ready_i` held high: one word per cycle, no bubbles. Total time is count+2 cycles from E0 to the final pop.
- `done_o` rises on the edge following the final pop. `busy_o` falls on that same edge.
- `ready_i` low for N cycles stalls issue after at most 2 buffered words. Streaming resumes with no lost or duplicated words.

## Configuration
- `TRB_READER_LAST_EN` defined: `last_o` is high together with `valid_o` on the final word of each readout. A buffer tag bit is carried per entry.
- Not defined: `last_o` is tied to 0, no tag storage exists, and the port remains.

## Structure
- `DTB_PKG` gains typedef `trb_rd_state_e` (`IDLE`, `RUN`, `DRAIN`).
- `DTB_PKG` keeps `TRB_ADDR_WIDTH`, `TRB_WIDTH` and `TRB_DEPTH` as the single source of widths.
- One sub-module, `trb_skid_fifo`: a 2-entry buffer with occupancy output, the same reset, and tag bit width 1 or 0 depending on the macro.

## Test plan
- ADDR_WIDTH=10, base=0x010, count=4, `ready_i`=1: `valid_o` from E2 for 4 cycles; data equals BRAM[0x010..0x013]; `done_o` pulses once; `last_o` on the 4th word if `TRB_READER_LAST_EN` is defined.
- base=0x3FE, count=4: addresses 0x3FE, 0x3FF, 0x000, 0x001 in order (wrap-around).
- count=0: no `valid_o`; `done_o` pulses on the cycle after start.
- count=1024 with random `ready_i` (~50%): 1024 words in order, no loss or duplication, `valid_o`/`data_o` stable while stalled.
- `abort_i` after 3 words of count=8: IDLE next cycle, `valid_o`=0, no `done_o`. A new start then reads correctly from its base.
- `rst_ni` low mid-RUN with 2 words buffered: all outputs go to reset values at once. `start_i` pulsed while busy: ignored, no effect.

Source files
------------

// File: rtl/dtb_pkg.sv
// dtb_pkg: shared trace-buffer widths, tag width and readout state type.
// TRB_READER_LAST_EN selects whether a per-word last tag is carried.
package dtb_pkg;
    localparam int TRB_ADDR_WIDTH = 10;
    localparam int TRB_WIDTH      = 32;
    localparam int TRB_DEPTH      = 1 << TRB_ADDR_WIDTH;
`ifdef TRB_READER_LAST_EN
    localparam int TRB_TAG_W      = 1;
`else
    localparam int TRB_TAG_W      = 0;
`endif
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} trb_rd_state_e;
endpackage

// File: rtl/trb_skid_fifo.sv
// trb_skid_fifo: 2-entry output buffer with occupancy and optional tag bit.
module trb_skid_fifo
    import dtb_pkg::*;
#(
    parameter int DW    = TRB_WIDTH,
    parameter int TAG_W = 0
) (
    input  logic                              clk,
    input  logic                              rst_ni,
    input  logic                              i_push,
    input  logic                              i_pop,
    input  logic                              i_flush,
    input  logic [DW-1:0]                     i_data,
    input  logic [(TAG_W > 0 ? TAG_W : 1)-1:0] i_tag,
    output logic [DW-1:0]                     o_data,
    output logic [(TAG_W > 0 ? TAG_W : 1)-1:0] o_tag,
    output logic                              o_valid,
    output logic [1:0]                        o_occ
);
    logic [DW-1:0] r_data [2];
    logic          r_wp, r_rp;
    logic [1:0]    r_occ;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data <= '{default: '0};
            r_wp   <= 1'b0;
            r_rp   <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            if (i_push) r_data[r_wp] <= i_data;
            if (i_flush) begin
                r_wp  <= 1'b0;
                r_rp  <= 1'b0;
                r_occ <= 2'd0;
            end else begin
                r_wp  <= r_wp ^ i_push;
                r_rp  <= r_rp ^ i_pop;
                r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
            end
        end
    end

    assign o_data  = r_data[r_rp];
    assign o_valid = r_occ != 2'd0;
    assign o_occ   = r_occ;

    if (TAG_W > 0) begin : g_tag
        logic [TAG_W-1:0] r_tag [2];
        always_ff @(posedge clk or negedge rst_ni) begin
            if (!rst_ni) r_tag <= '{default: '0};
            else if (i_push) r_tag[r_wp] <= i_tag;
        end
        assign o_tag = r_tag[r_rp];
    end else begin : g_notag
        logic w_unused;
        assign w_unused = &{1'b0, i_tag};
        assign o_tag    = '0;
    end
endmodule

// File: rtl/trb_stream_reader.sv
// trb_stream_reader: reads count words from base out of the trace BRAM as a valid/ready stream.
// Define TRB_READER_LAST_EN to flag the final word on last_o.
module trb_stream_reader
    import dtb_pkg::*;
#(
    parameter int ADDR_WIDTH = TRB_ADDR_WIDTH,
    parameter int DATA_WIDTH = TRB_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   count_i,
    input  logic                  abort_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    trb_rd_state_e         r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]         r_count, r_issued, w_cnt;
    logic                  r_inflight, r_done;
    logic [1:0]            w_occ;
    logic                  w_pop, w_start, w_abort, w_issue, w_final_issue, w_final_pop;
    logic [0:0]            w_tag_in, w_tag_out;

    assign w_cnt         = count_i > DEPTH ? DEPTH : count_i;
    assign w_pop         = valid_o & ready_i;
    assign w_start       = start_i && r_state == IDLE && w_cnt != '0;
    assign w_abort       = abort_i && r_state != IDLE;
    // Keeps buffered plus in-flight words within the 2-entry buffer.
    assign w_issue       = r_state == RUN && !abort_i &&
                           ({1'b0, w_occ} + {2'b0, r_inflight} < 3'd2 + {2'b0, w_pop});
    assign w_final_issue = w_issue && (r_issued + CW'(1) == r_count);
    assign w_final_pop   = r_state == DRAIN && !abort_i && w_pop && w_occ == 2'd1 && !r_inflight;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_start) w_next = RUN;
        else if (w_abort) w_next = IDLE;
        else if (w_final_issue) w_next = DRAIN;
        else if (w_final_pop) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_issued   <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr   <= base_addr_i;
                r_count  <= w_cnt;
                r_issued <= '0;
            end else if (w_issue) begin
                r_addr   <= r_addr + ADDR_WIDTH'(1);
                r_issued <= r_issued + CW'(1);
            end
            r_inflight <= w_issue;
            r_done     <= (start_i && r_state == IDLE && w_cnt == '0) || w_final_pop;
        end
    end

    trb_skid_fifo #(.DW(DATA_WIDTH), .TAG_W(TRB_TAG_W)) u_fifo (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_flush (w_abort),
        .i_data  (rd_data_i),
        .i_tag   (w_tag_in),
        .o_data  (data_o),
        .o_tag   (w_tag_out),
        .o_valid (valid_o),
        .o_occ   (w_occ)
    );

`ifdef TRB_READER_LAST_EN
    logic r_inflight_last;
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) r_inflight_last <= 1'b0;
        else r_inflight_last <= w_final_issue;
    end
    assign w_tag_in = r_inflight_last;
    assign last_o   = valid_o & w_tag_out[0];
`else
    logic w_unused;
    assign w_unused = w_tag_out[0];
    assign w_tag_in = 1'b0;
    assign last_o   = 1'b0;
`endif

    assign rd_addr_o = r_addr;
    assign busy_o    = r_state != IDLE;
    assign done_o    = r_done;
endmodule
